// File: rtl/cola_vend_ctrl.sv
// cola_vend_ctrl: transaction controller in front of the cola dispenser.
// Collects 0.5/1.0 coin pulses as half-unit credit, requests a dispense via a
// req/ack handshake once the price is reached, then pays change back one
// half-unit pulse every other cycle. A cancel in COLLECT refunds everything.
// Optional feature: define REFUND_TIMEOUT_EN to build the idle auto-refund
// timer (TIMEOUT_CYC idle cycles in COLLECT trigger a full refund).
module cola_vend_ctrl #(
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 15
`ifdef REFUND_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1000
`endif
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       pi_half,
    input  logic       pi_one,
    input  logic       pi_cancel,
    input  logic       pi_disp_ack,
    output logic       po_disp_req,
    output logic       po_change,
    output logic       po_coin_reject,
    output logic [3:0] po_credit,
    output logic       po_busy
);

    // One-hot state encoding
    localparam logic [3:0] S_IDLE    = 4'b0001;
    localparam logic [3:0] S_COLLECT = 4'b0010;
    localparam logic [3:0] S_VEND    = 4'b0100;
    localparam logic [3:0] S_PAYOUT  = 4'b1000;

    // Price and ceiling at the widths they are compared against
    localparam logic [4:0] PRICE_W = 5'(PRICE);
    localparam logic [3:0] PRICE_C = 4'(PRICE);
    localparam logic [4:0] MAX_W   = 5'(MAX_CREDIT);

    logic [3:0] state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic       change_q, change_d;
    logic       reject_q, reject_d;

    logic       coinAny;
    logic       coinFits;
    logic       coinAccepted;
    logic       timeoutHit;
    logic [4:0] coinAdd;
    logic [4:0] coinSum;

    // Coin value and the 5-bit tentative credit, so overflow past the ceiling is visible
    always_comb begin
        coinAny  = pi_half | pi_one;
        coinAdd  = {4'b0000, pi_half} + {3'b000, pi_one, 1'b0};
        coinSum  = {1'b0, credit_q} + coinAdd;
        coinFits = (coinSum <= MAX_W);
    end

`ifdef REFUND_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] timer_q, timer_d;

    // Timeout fires on the cycle the idle counter sits at its last value in COLLECT
    always_comb begin
        timeoutHit = (state_q == S_COLLECT) && (timer_q == TIMER_LAST);
    end

    // Count idle COLLECT cycles; any accepted coin or leaving COLLECT restarts the count
    always_comb begin
        if ((state_q == S_COLLECT) && (state_d == S_COLLECT) && !coinAccepted) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = '0;
        end
    end

    // Idle timer register
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    // Without the refund timer, COLLECT waits indefinitely for a coin or cancel
    always_comb begin
        timeoutHit = 1'b0;
    end
`endif

    // Next-state, credit and output pulse decisions
    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        change_d     = 1'b0;
        reject_d     = 1'b0;
        coinAccepted = 1'b0;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if ((state_q == S_COLLECT) && pi_cancel) begin
                    // Cancel wins over any coin in the same cycle; first change pulse next cycle
                    state_d  = S_PAYOUT;
                    change_d = 1'b1;
                    reject_d = coinAny;
                end else begin
                    if (coinAny) begin
                        if (coinFits) begin
                            coinAccepted = 1'b1;
                            credit_d     = coinSum[3:0];
                            state_d      = (coinSum >= PRICE_W) ? S_VEND : S_COLLECT;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                    if (!coinAccepted && timeoutHit) begin
                        state_d  = S_PAYOUT;
                        change_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                reject_d = coinAny;
                if (pi_disp_ack) begin
                    credit_d = credit_q - PRICE_C;
                    if (credit_q == PRICE_C) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_PAYOUT;
                        change_d = 1'b1;
                    end
                end
            end
            S_PAYOUT: begin
                reject_d = coinAny;
                if (change_q) begin
                    // The pulse being shown now pays out one half-unit
                    credit_d = credit_q - 4'd1;
                    if (credit_q <= 4'd1) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    change_d = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    // State, credit and registered output pulses
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            change_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            reject_q <= reject_d;
        end
    end

    assign po_credit      = credit_q;
    assign po_change      = change_q;
    assign po_coin_reject = reject_q;
    assign po_disp_req    = (state_q == S_VEND);
    assign po_busy        = (state_q == S_VEND) || (state_q == S_PAYOUT);

endmodule

// File: doc/cola_vend_ctrl.md
# cola_vend_ctrl

Transaction controller that sits in front of the cola dispenser. It accepts coin pulses from two slots (0.5-unit and 1-unit), arbitrates simultaneous coins, and accumulates credit in half-units. When credit reaches the price, it requests a dispense through a req/ack handshake. It then pays out change one half-unit pulse at a time, and supports a cancel/refund path.

## Interface
- PRICE, 5, price in half-units (5 = 2.5); legal range 1..MAX_CREDIT
- MAX_CREDIT, 15, credit ceiling in half-units; must fit in 4 bits
- TIMEOUT_CYC, 1000, idle cycles in COLLECT before auto-refund (only with REFUND_TIMEOUT_EN)
- sys_clk  input  1  single clock, all logic on its rising edge
- sys_rst  input  1  asynchronous, active-low reset
- pi_half  input  1  one-cycle pulse: 0.5 coin inserted (adds 1)
- pi_one  input  1  one-cycle pulse: 1.0 coin inserted (adds 2)
- pi_cancel  input  1  one-cycle pulse: customer requests refund
- pi_disp_ack  input  1  dispenser accepted the current request
- po_disp_req  output  1  dispense request, level, held until ack
- po_change  output  1  one-cycle pulse per half-unit returned
- po_coin_reject  output  1  one-cycle pulse: coin(s) of the previous cycle refused
- po_credit  output  4  current credit in half-units
- po_busy  output  1  high in VEND or PAYOUT

## Operation
- Reset values:
  - state = IDLE
  - all outputs 0
  - credit 0
  - payout toggle 0
  - timeout counter 0
- States are one-hot: IDLE, COLLECT, VEND, PAYOUT.
- Coin accept, IDLE/COLLECT only:
  - add = 1·pi_half + 2·pi_one; both coins in the same cycle add 3.
  - next credit = credit + add, computed in 5 bits.
  - If the sum exceeds MAX_CREDIT, the whole add is refused: credit unchanged, po_coin_reject pulses.
- Coins arriving in VEND or PAYOUT: always refused (po_coin_reject pulse, credit unchanged).
- IDLE -> COLLECT on an accepted coin with new credit < PRICE.
- IDLE/COLLECT -> VEND when the accepted new credit >= PRICE.
- COLLECT + pi_cancel -> PAYOUT. Cancel has priority over a same-cycle coin; that coin is refused.
- pi_cancel in IDLE, VEND or PAYOUT is ignored.
- VEND:
  - po_disp_req = 1.
  - On pi_disp_ack = 1: credit -= PRICE; go to PAYOUT if the remainder > 0, else IDLE.
  - pi_disp_ack outside VEND is ignored.
- PAYOUT:
  - po_change alternates 1,0,1,0…
  - Each high cycle decrements credit by 1.
  - After the pulse that takes credit to 0, the next state is IDLE.
- po_credit always shows the registered credit.

## Timing
- All outputs are registered.
- A coin pulse in cycle N appears in po_credit at N+1.
- If that coin makes credit reach PRICE, po_disp_req is high at N+1.
- po_coin_reject is high at N+1 for a refused coin in cycle N.
- Ack sampled in cycle M (req high):
  - po_disp_req low at M+1.
  - Credit reduced at M+1.
  - First po_change at M+1 if a remainder exists.
- Change payout: remainder R produces R pulses on cycles M+1, M+3, …, M+2R-1. State is IDLE at M+2R.
- Cancel in cycle C: first po_change at C+1, same spacing.
- po_busy follows the registered state: high from the cycle state = VEND until the cycle state returns to IDLE.
- Reset asserted mid-transaction:
  - immediate return to IDLE, credit 0, all outputs 0.
  - credit is lost (accepted behaviour; no refund).
- Ack held high continuously: only one vend is counted, because ack is consumed only in VEND.

## Configuration
- REFUND_TIMEOUT_EN defined:
  - In COLLECT, a counter increments every cycle without an accepted coin and clears on every accepted coin.
  - When it reaches TIMEOUT_CYC-1, the next state is PAYOUT (full refund), exactly as if pi_cancel had been pulsed.
  - The counter is cleared on leaving COLLECT.
- Not defined: no counter is built; COLLECT holds credit indefinitely until a coin or cancel.

## Test plan
- PRICE=5:
  - pi_one ×2, then pi_half, on separate cycles -> po_credit 2,4,5; po_disp_req high the cycle credit shows 5.
  - Ack -> credit 0, IDLE, no po_change.
- Credit 4, pi_one+pi_half in the same cycle -> credit 7, VEND. Ack -> credit 2, two po_change pulses two cycles apart, then IDLE.
- Credit 14, pi_one -> po_coin_reject pulse, credit stays 14.
  - Uses MAX_CREDIT=15, PRICE=15.
- Credit 3, pi_cancel together with pi_one -> coin rejected, three po_change pulses, credit 0, IDLE.
- In VEND, pi_half and pi_cancel both pulsed -> po_coin_reject, cancel ignored, po_disp_req stays high until ack.
- With REFUND_TIMEOUT_EN and TIMEOUT_CYC=8: credit 2, no activity -> PAYOUT after 8 cycles, two pulses.
  - Repeat with a coin at cycle 6: timer restarts.
  - Assert sys_rst low mid-PAYOUT -> all outputs 0 immediately.
